// File: rtl/button_pulser_pkg.sv
// Shared definitions for the button pulser: the per-channel debounce state
// encoding, the default timing constants and a counter-width helper.
package button_pulser_pkg;

    // Channel state, 2-bit binary encoding.
    typedef enum logic [1:0] {
        RELEASED   = 2'b00,
        PRESS_DB   = 2'b01,
        PRESSED    = 2'b10,
        RELEASE_DB = 2'b11
    } btn_state_e;

    // Defaults sized for a 50 MHz clock.
    localparam int unsigned DB_CYCLES_DEF  = 500000;    // 10 ms debounce
    localparam int unsigned REP_DELAY_DEF  = 25000000;  // 500 ms to first repeat
    localparam int unsigned REP_PERIOD_DEF = 5000000;   // 100 ms between repeats

    // Bits needed to hold every value from 0 up to max_val inclusive.
    function automatic int cnt_w(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM and auto-repeat.
// Ports:
//   clk_i   - system clock, rising edge
//   rst_ni  - synchronous active-low reset
//   btn_ni  - raw asynchronous button, 0 = pressed
//   pulse_o - registered one-cycle pulse request (initial press or repeat)
module btn_channel
    import button_pulser_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
    parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
    parameter int unsigned REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic pulse_o
);

    localparam int          DB_W    = cnt_w(DB_CYCLES);
    localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int          REP_W   = cnt_w(REP_MAX);
    localparam bit          REP_EN  = (REP_DELAY != 0);

    // Counters hold "samples seen so far"; the transition fires on the sample
    // that brings the total up to the limit, so they top out at limit-1.
    localparam logic [DB_W-1:0]  DB_ONE          = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST         = DB_W'((DB_CYCLES == 0) ? 0 : DB_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ONE         = REP_W'(1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'((REP_DELAY == 0) ? 0 : REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'((REP_PERIOD == 0) ? 0 : REP_PERIOD - 1);

    logic [1:0]       sync_q;       // [0] first stage, [1] synchronized level
    btn_state_e       state_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic [REP_W-1:0] rep_cnt_q;
    logic             rep_phase_q;  // 0: waiting REP_DELAY, 1: repeating every REP_PERIOD
    logic             pulse_q;

    logic             pressed;
    logic [REP_W-1:0] rep_last;

    assign pressed  = ~sync_q[1];
    assign rep_last = rep_phase_q ? REP_PERIOD_LAST : REP_DELAY_LAST;
    assign pulse_o  = pulse_q;

    // NOTE: every register here uses <= so all of them update from the values
    // they held before the edge; blocking writes would let later statements
    // see half-updated state and the synchronizer would collapse to one flop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q      <= 2'b11;
            state_q     <= RELEASED;
            db_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_ni};
            pulse_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (pressed) begin
                        state_q  <= PRESS_DB;
                        db_cnt_q <= DB_ONE;
                    end
                end
                PRESS_DB: begin
                    if (!pressed) begin
                        state_q  <= RELEASED;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q >= DB_LAST) begin
                        state_q     <= PRESSED;
                        db_cnt_q    <= '0;
                        rep_cnt_q   <= '0;
                        rep_phase_q <= 1'b0;
                        pulse_q     <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_ONE;
                    end
                end
                PRESSED: begin
                    if (!pressed) begin
                        state_q     <= RELEASE_DB;
                        db_cnt_q    <= DB_ONE;
                        rep_cnt_q   <= '0;
                        rep_phase_q <= 1'b0;
                    end else if (REP_EN) begin
                        if (rep_cnt_q >= rep_last) begin
                            rep_cnt_q   <= '0;
                            rep_phase_q <= 1'b1;
                            pulse_q     <= 1'b1;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + REP_ONE;
                        end
                    end
                end
                RELEASE_DB: begin
                    if (pressed) begin
                        // Bounce back to held: no new pulse, repeat timing restarts.
                        state_q     <= PRESSED;
                        db_cnt_q    <= '0;
                        rep_cnt_q   <= '0;
                        rep_phase_q <= 1'b0;
                    end else if (db_cnt_q >= DB_LAST) begin
                        state_q  <= RELEASED;
                        db_cnt_q <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_ONE;
                    end
                end
                default: state_q <= RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/button_pulser.sv
// Two debounced pushbuttons turned into increment/decrement requests for the
// 2-bit 7-seg counter FSM. Simultaneous requests cancel each other.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-low reset
//   btn_up_n - raw up button, 0 = pressed
//   btn_dn_n - raw down button, 0 = pressed
//   inc      - registered one-cycle increment request
//   dec      - registered one-cycle decrement request
module button_pulser
    import button_pulser_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
    parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
    parameter int unsigned REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_n,
    input  logic btn_dn_n,
    output logic inc,
    output logic dec
);

    logic up_pulse;
    logic dn_pulse;
    logic inc_d, inc_q;
    logic dec_d, dec_q;

    btn_channel #(
        .DB_CYCLES (DB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
    ) u_up (
        .clk_i  (clk),
        .rst_ni (rst),
        .btn_ni (btn_up_n),
        .pulse_o(up_pulse)
    );

    btn_channel #(
        .DB_CYCLES (DB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
    ) u_dn (
        .clk_i  (clk),
        .rst_ni (rst),
        .btn_ni (btn_dn_n),
        .pulse_o(dn_pulse)
    );

    // A coincident up/down request is ambiguous, so it is dropped entirely.
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    always_comb begin
        inc_d = 1'b0;
        dec_d = 1'b0;
        if (up_pulse && !dn_pulse) inc_d = 1'b1;
        if (dn_pulse && !up_pulse) dec_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            inc_q <= inc_d;
            dec_q <= dec_d;
        end
    end

    assign inc = inc_q;
    assign dec = dec_q;

endmodule

// File: tb/tb_button_pulser.sv
// Scoreboard bench for button_pulser with DB_CYCLES=4, REP_DELAY=10,
// REP_PERIOD=3. Stimulus pushes {edge number, inc/dec} for every pulse it
// expects; the monitor pops one entry per observed pulse. Edge E0 is the first
// rising edge that samples a new raw input value.
module tb_button_pulser;

    localparam int unsigned DB  = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 3;
    localparam int          LAT = 2 + DB;   // raw-low sample edge to pulse edge

    typedef struct {
        int cyc;
        bit is_dec;
    } exp_t;

    logic clk;
    logic rst;
    logic btn_up_n;
    logic btn_dn_n;
    logic inc;
    logic dec;

    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   mon_en;
    exp_t exp_q[$];

    button_pulser #(
        .DB_CYCLES (DB),
        .REP_DELAY (RD),
        .REP_PERIOD(RP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up_n(btn_up_n),
        .btn_dn_n(btn_dn_n),
        .inc     (inc),
        .dec     (dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // After rising edge k (counting from 1) cyc reads k.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expect_pulse(input int at, input bit is_dec);
        exp_t e;
        e.cyc    = at;
        e.is_dec = is_dec;
        exp_q.push_back(e);
    endtask

    // Advance n rising edges; inputs changed afterwards are first sampled on
    // the next edge, i.e. at edge cyc+1.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic end_test(input string name);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("inc_dec_exclusive", 64'(inc & dec), 64'd0);
                if (inc || dec) begin
                    check("pulse_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("pulse_edge", 64'(cyc), 64'(e.cyc));
                        check("pulse_is_dec", 64'(dec), 64'(e.is_dec));
                    end
                end
            end
        end
    end

    initial begin
        int e0;
        int rep_edges[6];
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;

        // Reset with the up button already held through deassertion.
        rst      = 1'b0;
        btn_up_n = 1'b0;
        btn_dn_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_inc", 64'(inc), 64'd0);
            check("reset_dec", 64'(dec), 64'd0);
        end
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        e0     = cyc + 1;            // first edge with rst=1
        expect_pulse(e0 + LAT, 1'b0);
        tick(8);
        btn_up_n = 1'b1;
        tick(20);
        end_test("reset_held");

        // Clean press: low for 8 samples, one inc at E6 only.
        e0 = cyc + 1;
        btn_up_n = 1'b0;
        expect_pulse(e0 + LAT, 1'b0);
        tick(8);
        btn_up_n = 1'b1;
        tick(20);
        end_test("clean_press");

        // Bounce on dn: 0,1,0,1 then low from E4; one dec at E4+6.
        e0 = cyc + 1;
        btn_dn_n = 1'b0; tick(1);
        btn_dn_n = 1'b1; tick(1);
        btn_dn_n = 1'b0; tick(1);
        btn_dn_n = 1'b1; tick(1);
        btn_dn_n = 1'b0;
        expect_pulse(e0 + 4 + LAT, 1'b1);
        tick(8);
        btn_dn_n = 1'b1;
        tick(20);
        end_test("bounce");

        // Auto-repeat: last low sample at E27 is the edge the sixth request
        // registers, so exactly six pulses appear and none after release.
        rep_edges = '{6, 16, 19, 22, 25, 28};
        e0 = cyc + 1;
        btn_up_n = 1'b0;
        for (int i = 0; i < 6; i++) expect_pulse(e0 + rep_edges[i], 1'b0);
        tick(28);
        btn_up_n = 1'b1;
        tick(20);
        end_test("auto_repeat");

        // Simultaneous press: every request coincides and is suppressed.
        btn_up_n = 1'b0;
        btn_dn_n = 1'b0;
        tick(30);
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        tick(20);
        end_test("simultaneous");

        // Staggered presses: both channels pulse on their own.
        e0 = cyc + 1;
        btn_up_n = 1'b0;
        expect_pulse(e0 + LAT, 1'b0);
        tick(3);
        btn_dn_n = 1'b0;
        expect_pulse(e0 + 3 + LAT, 1'b1);
        tick(7);
        btn_up_n = 1'b1;
        tick(3);
        btn_dn_n = 1'b1;
        tick(20);
        end_test("staggered");

        // Release glitch: high at E8,E9, low again from E10. The channel
        // re-enters PRESSED at E12 without a pulse; the repeat request
        // registers REP_DELAY later (E22), output at E23, then E26.
        e0 = cyc + 1;
        btn_up_n = 1'b0;
        expect_pulse(e0 + LAT, 1'b0);
        expect_pulse(e0 + 23, 1'b0);
        expect_pulse(e0 + 26, 1'b0);
        tick(8);
        btn_up_n = 1'b1;
        tick(2);
        btn_up_n = 1'b0;
        tick(16);
        btn_up_n = 1'b1;
        tick(20);
        end_test("release_glitch");

        // Reset mid-debounce: aborted, then a fresh debounce with the button
        // still held gives one pulse 6 edges after the first edge with rst=1.
        btn_up_n = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        e0 = cyc + 1;
        expect_pulse(e0 + LAT, 1'b0);
        tick(8);
        btn_up_n = 1'b1;
        tick(20);
        end_test("reset_mid_debounce");

        // Reset mid-repeat: the pending request (would be at E16) is lost.
        e0 = cyc + 1;
        btn_up_n = 1'b0;
        expect_pulse(e0 + LAT, 1'b0);
        tick(12);
        rst = 1'b0;
        tick(2);
        btn_up_n = 1'b1;
        rst = 1'b1;
        tick(20);
        end_test("reset_mid_repeat");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
